// File: rtl/oflow_buffer_fsm_write.sv
// -----------------------------------------------------------------------------
// oflow_buffer_fsm_write
//
// Buffer-side receiver for the core write handshake. A one-cycle
// ready_from_core pulse presents up to four bbox records on a four-lane bus;
// the block stores them into frame memory as one or two rows of two records
// and pulses done_write_buffer on the last row of the beat. A running row
// pointer and a saturating per-frame bbox count are maintained; start_frame
// clears both and aborts any beat in flight.
//
// Optional feature macro: OFLOW_BUF_WR_OVERFLOW_CHECK_EN
//   defined   : overflow_err is a sticky flag (cleared by start_frame/reset),
//               set by a ready_from_core pulse while busy or by a write
//               attempted after the pointer has wrapped within the frame;
//               such post-wrap writes are suppressed (mem_we=0).
//   undefined : overflow_err is 0, wrapping writes overwrite old rows.
//
// Ports:
//   clk                clock
//   reset_N            asynchronous active-low reset
//   start_frame        new-frame pulse, clears pointer and count
//   ready_from_core    lanes valid this cycle
//   remainder          0 -> 4 valid lanes, 1..3 -> lanes 0..remainder-1
//   bbox_data_in       lane k at [(k+1)*WORD_W-1 : k*WORD_W]
//   mem_we/addr/wdata  frame-memory row write, wdata = {upper, lower}
//   mem_be             word enables, bit0 lower, bit1 upper
//   done_write_buffer  pulse on the last write of a beat
//   frame_bbox_count   bboxes written since start_frame (saturating)
//   busy               high whenever a row write is in progress
//   overflow_err       sticky overflow flag (see macro above)
// All outputs are registered and equal the decode of the current state.
// -----------------------------------------------------------------------------
module oflow_buffer_fsm_write #(
    parameter int WORD_W = 64,
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 12
) (
    input  logic                  clk,
    input  logic                  reset_N,
    input  logic                  start_frame,
    input  logic                  ready_from_core,
    input  logic [1:0]            remainder,
    input  logic [4*WORD_W-1:0]   bbox_data_in,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [2*WORD_W-1:0]   mem_wdata,
    output logic [1:0]            mem_be,
    output logic                  done_write_buffer,
    output logic [CNT_W-1:0]      frame_bbox_count,
    output logic                  busy,
    output logic                  overflow_err
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WR_ROW0 = 2'd1,
        ST_WR_ROW1 = 2'd2
    } state_t;

    // Number of valid lanes carried by a beat.
    function automatic logic [2:0] lane_count(input logic [1:0] rem);
        lane_count = (rem == 2'd0) ? 3'd4 : {1'b0, rem};
    endfunction

    // Saturating add of a beat's lane count onto the frame counter.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [2:0]       b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + {{(CNT_W-2){1'b0}}, b};
        if (s[CNT_W]) begin
            sat_add = {CNT_W{1'b1}};
        end else begin
            sat_add = s[CNT_W-1:0];
        end
    endfunction

    state_t                r_state, w_state_nxt;
    logic [ADDR_W-1:0]     r_ptr, w_ptr_nxt, w_ptr_inc;
    logic [2*WORD_W-1:0]   r_cap_hi, w_cap_hi_nxt;   // lanes 3..2 of the beat
    logic [2:0]            r_valid, w_valid_nxt, w_lanes;
    logic [CNT_W-1:0]      r_count, w_count_nxt;
    logic                  r_we, w_we_nxt;
    logic [ADDR_W-1:0]     r_addr, w_addr_nxt;
    logic [2*WORD_W-1:0]   r_wdata, w_wdata_nxt;
    logic [1:0]            r_be, w_be_nxt;
    logic                  r_done, w_done_nxt;
    logic                  r_busy;

`ifdef OFLOW_BUF_WR_OVERFLOW_CHECK_EN
    logic                  r_wrapped, w_wrapped_nxt;  // ptr wrapped this frame
    logic                  r_err, w_err_nxt;
    logic                  w_at_top;
    assign w_at_top = (r_ptr == {ADDR_W{1'b1}});
`endif

    assign w_ptr_inc = r_ptr + {{(ADDR_W-1){1'b0}}, 1'b1};

    // Next-state, next-pointer and next-output decode.
    always_comb begin
        w_state_nxt  = r_state;
        w_ptr_nxt    = r_ptr;
        w_cap_hi_nxt = r_cap_hi;
        w_valid_nxt  = r_valid;
        w_count_nxt  = r_count;
        w_we_nxt     = 1'b0;
        w_addr_nxt   = '0;
        w_wdata_nxt  = '0;
        w_be_nxt     = 2'b00;
        w_done_nxt   = 1'b0;
        w_lanes      = lane_count(remainder);
`ifdef OFLOW_BUF_WR_OVERFLOW_CHECK_EN
        w_wrapped_nxt = r_wrapped;
        w_err_nxt     = r_err;
`endif
        if (start_frame) begin
            // New frame wins over everything, including a same-cycle pulse.
            w_state_nxt = ST_IDLE;
            w_ptr_nxt   = '0;
            w_count_nxt = '0;
`ifdef OFLOW_BUF_WR_OVERFLOW_CHECK_EN
            w_wrapped_nxt = 1'b0;
            w_err_nxt     = 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (ready_from_core) begin
                        w_cap_hi_nxt = bbox_data_in[4*WORD_W-1:2*WORD_W];
                        w_valid_nxt  = w_lanes;
                        w_state_nxt  = ST_WR_ROW0;
                        // Row 0 is issued straight from the bus.
`ifdef OFLOW_BUF_WR_OVERFLOW_CHECK_EN
                        w_we_nxt     = ~r_wrapped;
`else
                        w_we_nxt     = 1'b1;
`endif
                        w_addr_nxt   = r_ptr;
                        w_wdata_nxt  = bbox_data_in[2*WORD_W-1:0];
                        w_be_nxt     = (w_lanes == 3'd1) ? 2'b01 : 2'b11;
                        w_done_nxt   = (w_lanes <= 3'd2);
                    end else begin
                        w_state_nxt  = ST_IDLE;
                    end
                end
                ST_WR_ROW0: begin
                    w_ptr_nxt = w_ptr_inc;
`ifdef OFLOW_BUF_WR_OVERFLOW_CHECK_EN
                    if (w_at_top) begin
                        w_wrapped_nxt = 1'b1;
                    end else begin
                        w_wrapped_nxt = r_wrapped;
                    end
                    if (r_wrapped || ready_from_core) begin
                        w_err_nxt = 1'b1;
                    end else begin
                        w_err_nxt = r_err;
                    end
`endif
                    if (r_valid <= 3'd2) begin
                        w_state_nxt = ST_IDLE;
                        w_count_nxt = sat_add(r_count, r_valid);
                    end else begin
                        w_state_nxt = ST_WR_ROW1;
`ifdef OFLOW_BUF_WR_OVERFLOW_CHECK_EN
                        w_we_nxt    = ~(r_wrapped | w_at_top);
`else
                        w_we_nxt    = 1'b1;
`endif
                        w_addr_nxt  = w_ptr_inc;
                        w_wdata_nxt = r_cap_hi;
                        w_be_nxt    = (r_valid == 3'd3) ? 2'b01 : 2'b11;
                        w_done_nxt  = 1'b1;
                    end
                end
                ST_WR_ROW1: begin
                    w_ptr_nxt   = w_ptr_inc;
                    w_state_nxt = ST_IDLE;
                    w_count_nxt = sat_add(r_count, r_valid);
`ifdef OFLOW_BUF_WR_OVERFLOW_CHECK_EN
                    if (w_at_top) begin
                        w_wrapped_nxt = 1'b1;
                    end else begin
                        w_wrapped_nxt = r_wrapped;
                    end
                    if (r_wrapped || ready_from_core) begin
                        w_err_nxt = 1'b1;
                    end else begin
                        w_err_nxt = r_err;
                    end
`endif
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // State, pointer, capture and registered output update.
    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) begin
            r_state  <= ST_IDLE;
            r_ptr    <= '0;
            r_cap_hi <= '0;
            r_valid  <= 3'd0;
            r_count  <= '0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_be     <= 2'b00;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_ptr    <= w_ptr_nxt;
            r_cap_hi <= w_cap_hi_nxt;
            r_valid  <= w_valid_nxt;
            r_count  <= w_count_nxt;
            r_we     <= w_we_nxt;
            r_addr   <= w_addr_nxt;
            r_wdata  <= w_wdata_nxt;
            r_be     <= w_be_nxt;
            r_done   <= w_done_nxt;
            r_busy   <= (w_state_nxt != ST_IDLE);
        end
    end

`ifdef OFLOW_BUF_WR_OVERFLOW_CHECK_EN
    // Overflow tracking state.
    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) begin
            r_wrapped <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_wrapped <= w_wrapped_nxt;
            r_err     <= w_err_nxt;
        end
    end
    assign overflow_err = r_err;
`else
    assign overflow_err = 1'b0;
`endif

    assign mem_we            = r_we;
    assign mem_addr          = r_addr;
    assign mem_wdata         = r_wdata;
    assign mem_be            = r_be;
    assign done_write_buffer = r_done;
    assign frame_bbox_count  = r_count;
    assign busy              = r_busy;

endmodule

// File: doc/oflow_buffer_fsm_write.md
Name: oflow_buffer_fsm_write

Overview:
Buffer-side receiver for the core write handshake. Each one-cycle `ready_from_core` pulse (with `remainder`) marks up to 4 bboxes on the 4-lane data bus. The block captures them and writes them into frame memory as up to 2 rows of 2 bboxes each. It pulses `done_write_buffer` and keeps a running write pointer and bbox count for the frame.

Parameters:
WORD_W, 64, width of one bbox record
ADDR_W, 10, frame-memory row address width (depth = 2**ADDR_W rows)
CNT_W, 12, width of frame bbox counter

Ports:
clk  in  1  clock
reset_N  in  1  asynchronous active-low reset
start_frame  in  1  one-cycle pulse: new frame, clears pointer/count
ready_from_core  in  1  one-cycle pulse: lanes valid this cycle
remainder  in  2  0 = 4 valid lanes; 1/2/3 = only lanes 0..remainder-1 valid
bbox_data_in  in  4*WORD_W  lane k at bits [(k+1)*WORD_W-1 : k*WORD_W]
mem_we  out  1  memory write strobe
mem_addr  out  ADDR_W  memory row address
mem_wdata  out  2*WORD_W  {upper word, lower word}
mem_be  out  2  word enables: bit0 lower, bit1 upper
done_write_buffer  out  1  one-cycle pulse on last write of a beat
frame_bbox_count  out  CNT_W  bboxes written since start_frame
busy  out  1  high in any state other than IDLE
overflow_err  out  1  sticky error (see Optional Feature)

Behaviour:
- Reset (async, reset_N=0): state IDLE.
  - All outputs 0; write pointer 0; capture register 0.
  - Reset mid-beat abandons the beat; no partial write is completed.
- States: IDLE, WR_ROW0, WR_ROW1.
- IDLE:
  - On ready_from_core: register bbox_data_in and remainder; go to WR_ROW0.
  - Compute the number of valid lanes: remainder 0 → 4, otherwise → remainder.
- WR_ROW0 (1 cycle):
  - mem_we=1, mem_addr=ptr, mem_wdata={lane1,lane0}.
  - mem_be = 2'b01 if valid=1, else 2'b11.
  - ptr increments.
  - If valid ≤ 2: done_write_buffer=1 this cycle; go to IDLE. Otherwise go to WR_ROW1.
- WR_ROW1 (1 cycle):
  - mem_we=1, mem_wdata={lane3,lane2}.
  - mem_be = 2'b01 if valid=3, else 2'b11.
  - ptr increments; done_write_buffer=1; go to IDLE.
- Latency: first write 1 cycle after the ready pulse; done at t+1 (1–2 lanes) or t+2 (3–4 lanes).
  - The core spaces pulses at least 3 cycles apart, so the block is back in IDLE before the next pulse.
- frame_bbox_count:
  - Adds the valid count in the cycle done_write_buffer is asserted.
  - Saturates at all-ones.
- Write pointer:
  - Wraps modulo 2**ADDR_W.
  - A row that carried a 1-lane mask still consumes a full row; the next beat starts on a fresh row.
- start_frame:
  - In any state, next edge: ptr=0, frame_bbox_count=0, state IDLE, any in-flight beat aborted with no done.
  - Has priority over a simultaneous ready_from_core, which is dropped.
- ready_from_core while busy: never accepted; the in-flight beat completes unaffected.
- mem_we, mem_be and done_write_buffer are registered-state decodes: high only in WR states, 0 in IDLE.

Optional Feature:
OFLOW_BUF_WR_OVERFLOW_CHECK_EN
- Defined:
  - overflow_err sets when ready_from_core arrives while busy, or when a write would bring ptr to wrap back to 0 after leaving 0 in the current frame.
  - Stays set until start_frame or reset.
  - Overflowing wrap writes are suppressed (mem_we=0).
- Undefined:
  - overflow_err is constant 0.
  - Wrap writes proceed and overwrite old rows.
  - ready_from_core while busy is silently ignored.

Test Plan:
- Reset, start_frame, one pulse with remainder=0 and lanes A,B,C,D:
  - t+1: addr0 {B,A} be=11.
  - t+2: addr1 {D,C} be=11, done=1.
  - count=4.
- Pulse with remainder=1, then remainder=3:
  - addr0 {x,A} be=01, done at t+1.
  - Next beat: addr1 {B,A} be=11, then addr2 {x,C} be=01.
  - count=4.
- Six pulses every 3 cycles with remainder=0 (one 24-PE row):
  - 12 writes to addresses 0–11, six done pulses, count=24, busy never stuck.
- ready_from_core at t+1 of a 4-lane beat:
  - Ignored; writes unchanged.
  - overflow_err=1 only when OFLOW_BUF_WR_OVERFLOW_CHECK_EN is defined.
- start_frame asserted in WR_ROW0, then reset_N low mid-beat:
  - No done pulse; ptr and count return to 0.
  - After reset deassert, outputs stay 0.
- ADDR_W=2, three 4-lane beats:
  - Without the macro: 6 writes wrap to address 0,1.
  - With the macro: writes stop at address 3 and overflow_err=1.
